if_id_decode_reg: RTL and testbench

- IF/ID pipeline register for the MIPS core.
- Captures the fetched instruction and PC+4 each cycle.
- Pre-decodes the 16-bit immediate and the 2-bit extension-control code for the ID-stage immediate extender (00 sign, 01 zero, 10 lui, 11 zero output).
- Supports hazard-unit stall and branch/jump flush, so the extender and register file always see a stable, consistent instruction.

---
 rtl/if_id_decode_reg.sv | 75 +++++++
 tb/tb_if_id_decode_reg.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_id_decode_reg.sv
// IF/ID pipeline register with immediate pre-decode.
// Captures the fetched instruction word and PC+4, and registers the 2-bit
// extension control for the ID-stage immediate extender. The code is
// registered alongside the word, so ID needs no decode logic of its own.
// Stall holds every output. Flush and reset both insert a bubble.
module if_id_decode_reg #(
  parameter logic [31:0] PC_RESET  = 32'h0000_3000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  input  logic        flush,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc4_in,
  input  logic        valid_in,
  output logic [31:0] instr_out,
  output logic [31:0] pc4_out,
  output logic        valid_out,
  output logic [15:0] imm16,
  output logic [1:0]  ext_ctrl,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd
);

  localparam logic [1:0] EXT_SIGN = 2'b00;
  localparam logic [1:0] EXT_ZERO = 2'b01;
  localparam logic [1:0] EXT_LUI  = 2'b10;
  localparam logic [1:0] EXT_NONE = 2'b11;

  // Opcode -> extender mode. Anything without a 16-bit immediate
  // (R-type, j/jal, unknown) selects the zero-output mode.
  function automatic logic [1:0] decode_ext(input logic [5:0] op);
    logic [1:0] code;
    case (op)
      6'b001000, 6'b001001, 6'b001010, 6'b001011,  // addi addiu slti sltiu
      6'b100011, 6'b101011,                        // lw sw
      6'b100000, 6'b100100, 6'b100001, 6'b100101,  // lb lbu lh lhu
      6'b101000, 6'b101001,                        // sb sh
      6'b000100, 6'b000101:                        // beq bne
        code = EXT_SIGN;
      6'b001100, 6'b001101, 6'b001110:             // andi ori xori
        code = EXT_ZERO;
      6'b001111:                                   // lui
        code = EXT_LUI;
      default:
        code = EXT_NONE;
    endcase
    return code;
  endfunction

  // Pipeline register: reset/flush insert a bubble, en=0 holds, else load.
  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      instr_out <= NOP_INSTR;
      pc4_out   <= PC_RESET;
      valid_out <= 1'b0;
      ext_ctrl  <= EXT_NONE;
    end else if (en) begin
      instr_out <= instr_in;
      pc4_out   <= pc4_in;
      valid_out <= valid_in;
      ext_ctrl  <= decode_ext(instr_in[31:26]);
    end
  end

  // Field taps come straight off the captured word, so they always agree
  // with ext_ctrl.
  assign imm16 = instr_out[15:0];
  assign rs    = instr_out[25:21];
  assign rt    = instr_out[20:16];
  assign rd    = instr_out[15:11];

endmodule

// File: tb/tb_if_id_decode_reg.sv
// Self-checking bench for if_id_decode_reg: directed scenarios plus a
// randomized run against a behavioural model of the register.
module tb_if_id_decode_reg;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        en = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] instr_in = 32'h0;
  logic [31:0] pc4_in = 32'h0;
  logic        valid_in = 1'b0;
  logic [31:0] instr_out, pc4_out;
  logic        valid_out;
  logic [15:0] imm16;
  logic [1:0]  ext_ctrl;
  logic [4:0]  rs, rt, rd;

  int errors = 0;
  int checks = 0;

  // Model state
  logic [31:0] m_instr, m_pc4;
  logic        m_valid;
  logic [1:0]  m_ext;

  logic [5:0] sign_ops [14] = '{6'd8, 6'd9, 6'd10, 6'd11, 6'd35, 6'd43, 6'd32,
                                6'd36, 6'd33, 6'd37, 6'd40, 6'd41, 6'd4, 6'd5};
  logic [5:0] zero_ops [3]  = '{6'd12, 6'd13, 6'd14};

  if_id_decode_reg dut (
    .clk(clk), .reset_n(reset_n), .en(en), .flush(flush),
    .instr_in(instr_in), .pc4_in(pc4_in), .valid_in(valid_in),
    .instr_out(instr_out), .pc4_out(pc4_out), .valid_out(valid_out),
    .imm16(imm16), .ext_ctrl(ext_ctrl), .rs(rs), .rt(rt), .rd(rd)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] ref_ext(input logic [5:0] op);
    foreach (sign_ops[i]) if (sign_ops[i] == op) return 2'b00;
    foreach (zero_ops[i]) if (zero_ops[i] == op) return 2'b01;
    if (op == 6'd15) return 2'b10;
    return 2'b11;
  endfunction

  // Advance one edge, update the model from the inputs seen at that edge.
  task automatic tick();
    @(posedge clk);
    if (!reset_n || flush) begin
      m_instr = 32'h0; m_pc4 = 32'h0000_3000; m_valid = 1'b0; m_ext = 2'b11;
    end else if (en) begin
      m_instr = instr_in; m_pc4 = pc4_in; m_valid = valid_in;
      m_ext = ref_ext(instr_in[31:26]);
    end
    #1;
  endtask

  task automatic test_reset();
    reset_n = 0; en = 1; flush = 0; valid_in = 1;
    instr_in = 32'h3C01_1234; pc4_in = 32'h0000_0104;
    tick(); tick();
    checks++;
    if ({instr_out, pc4_out, valid_out, ext_ctrl} !== {32'h0, 32'h0000_3000, 1'b0, 2'b11}) begin
      errors++;
      $display("FAIL reset: got instr=%h pc4=%h v=%b ext=%b want 0/00003000/0/11",
               instr_out, pc4_out, valid_out, ext_ctrl);
    end
    checks++;
    if ({imm16, rs, rt, rd} !== 31'h0) begin
      errors++;
      $display("FAIL reset_fields: got imm=%h rs=%0d rt=%0d rd=%0d want all 0", imm16, rs, rt, rd);
    end
    reset_n = 1;
    tick();
    checks++;
    if ({instr_out, ext_ctrl, imm16, rt, pc4_out, valid_out} !==
        {32'h3C01_1234, 2'b10, 16'h1234, 5'd1, 32'h0000_0104, 1'b1}) begin
      errors++;
      $display("FAIL reset_release: got instr=%h ext=%b imm=%h rt=%0d pc4=%h v=%b want 3c011234/10/1234/1/00000104/1",
               instr_out, ext_ctrl, imm16, rt, pc4_out, valid_out);
    end
  endtask

  task automatic test_load_seq();
    logic [31:0] words [4] = '{32'h2402_FFFF, 32'h3443_8000, 32'h8C24_0004, 32'h0022_1820};
    logic [1:0]  exts  [4] = '{2'b00, 2'b01, 2'b00, 2'b11};
    en = 1; flush = 0; valid_in = 1;
    for (int i = 0; i < 4; i++) begin
      instr_in = words[i]; pc4_in = 32'h0000_3004 + 32'(4 * i);
      tick();
      checks++;
      if ({instr_out, ext_ctrl, pc4_out} !== {words[i], exts[i], 32'h0000_3004 + 32'(4 * i)}) begin
        errors++;
        $display("FAIL load_seq[%0d]: got instr=%h ext=%b pc4=%h want %h/%b/%h", i,
                 instr_out, ext_ctrl, pc4_out, words[i], exts[i], 32'h0000_3004 + 32'(4 * i));
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] next_w, next_pc;
    en = 1; instr_in = 32'h3443_8000; pc4_in = 32'h0000_3100; valid_in = 1;
    tick();
    en = 0;
    for (int i = 0; i < 3; i++) begin
      instr_in = $urandom; pc4_in = $urandom; valid_in = 1'($urandom);
      tick();
      checks++;
      if ({instr_out, pc4_out, valid_out, ext_ctrl} !== {32'h3443_8000, 32'h0000_3100, 1'b1, 2'b01}) begin
        errors++;
        $display("FAIL stall[%0d]: got instr=%h pc4=%h v=%b ext=%b want 34438000/00003100/1/01",
                 i, instr_out, pc4_out, valid_out, ext_ctrl);
      end
    end
    next_w = 32'h8C24_0004; next_pc = 32'h0000_3104;
    en = 1; instr_in = next_w; pc4_in = next_pc; valid_in = 1;
    tick();
    checks++;
    if ({instr_out, pc4_out, ext_ctrl} !== {next_w, next_pc, 2'b00}) begin
      errors++;
      $display("FAIL stall_resume: got instr=%h pc4=%h ext=%b want %h/%h/00",
               instr_out, pc4_out, ext_ctrl, next_w, next_pc);
    end
  endtask

  task automatic test_flush();
    en = 1; instr_in = 32'h3443_8000; pc4_in = 32'h0000_3200; valid_in = 1;
    tick();
    en = 0; flush = 1;
    tick();
    flush = 0;
    checks++;
    if ({instr_out, pc4_out, valid_out, ext_ctrl} !== {32'h0, 32'h0000_3000, 1'b0, 2'b11}) begin
      errors++;
      $display("FAIL flush: got instr=%h pc4=%h v=%b ext=%b want 0/00003000/0/11",
               instr_out, pc4_out, valid_out, ext_ctrl);
    end
  endtask

  task automatic test_invalid();
    en = 1; flush = 0; valid_in = 0; instr_in = 32'h3C05_ABCD; pc4_in = 32'h0000_3300;
    tick();
    valid_in = 1;
    checks++;
    if ({valid_out, ext_ctrl, imm16, rt} !== {1'b0, 2'b10, 16'hABCD, 5'd5}) begin
      errors++;
      $display("FAIL invalid_load: got v=%b ext=%b imm=%h rt=%0d want 0/10/abcd/5",
               valid_out, ext_ctrl, imm16, rt);
    end
  endtask

  task automatic test_reset_in_stall();
    en = 1; instr_in = 32'h2402_FFFF; pc4_in = 32'h0000_3400; valid_in = 1;
    tick();
    en = 0; reset_n = 0;
    tick();
    checks++;
    if ({instr_out, pc4_out, valid_out, ext_ctrl} !== {32'h0, 32'h0000_3000, 1'b0, 2'b11}) begin
      errors++;
      $display("FAIL reset_in_stall: got instr=%h pc4=%h v=%b ext=%b want 0/00003000/0/11",
               instr_out, pc4_out, valid_out, ext_ctrl);
    end
    reset_n = 1; en = 1; instr_in = 32'h3C01_1234; pc4_in = 32'h0000_3404;
    tick();
    checks++;
    if ({instr_out, pc4_out, valid_out, ext_ctrl} !== {32'h3C01_1234, 32'h0000_3404, 1'b1, 2'b10}) begin
      errors++;
      $display("FAIL reset_stall_release: got instr=%h pc4=%h v=%b ext=%b want 3c011234/00003404/1/10",
               instr_out, pc4_out, valid_out, ext_ctrl);
    end
  endtask

  // Every opcode once, compared to the model's lookup tables.
  task automatic test_decode_sweep();
    en = 1; flush = 0; reset_n = 1; valid_in = 1;
    for (int op = 0; op < 64; op++) begin
      instr_in = {6'(op), 26'($urandom)}; pc4_in = $urandom;
      tick();
      checks++;
      if (ext_ctrl !== m_ext || instr_out !== m_instr) begin
        errors++;
        $display("FAIL decode_op%0d: got ext=%b instr=%h want ext=%b instr=%h",
                 op, ext_ctrl, instr_out, m_ext, m_instr);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      reset_n  = ($urandom_range(0, 24) != 0);
      flush    = ($urandom_range(0, 9) == 0);
      en       = ($urandom_range(0, 3) != 0);
      valid_in = 1'($urandom);
      instr_in = $urandom; pc4_in = $urandom & 32'hFFFF_FFFC;
      tick();
      checks++;
      if ({instr_out, pc4_out, valid_out, ext_ctrl, imm16, rs, rt, rd} !==
          {m_instr, m_pc4, m_valid, m_ext, m_instr[15:0], m_instr[25:21], m_instr[20:16], m_instr[15:11]}) begin
        errors++;
        $display("FAIL random[%0d]: got instr=%h pc4=%h v=%b ext=%b imm=%h rs=%0d rt=%0d rd=%0d want instr=%h pc4=%h v=%b ext=%b",
                 i, instr_out, pc4_out, valid_out, ext_ctrl, imm16, rs, rt, rd,
                 m_instr, m_pc4, m_valid, m_ext);
      end
    end
    reset_n = 1; flush = 0;
  endtask

  initial begin
    #2;
    test_reset();
    test_load_seq();
    test_stall();
    test_flush();
    test_invalid();
    test_reset_in_stall();
    test_decode_sweep();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
